// File: rtl/two_level_solver_pkg.sv
// ============================================================================
// Module  : two_level_pkg
// Brief   : Shared types and constants for the two-level function solver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package two_level_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int A_BIT = 3;
    localparam int B_BIT = 2;
    localparam int C_BIT = 1;
    localparam int D_BIT = 0;
    localparam int N_VEC = 16;

endpackage

`default_nettype wire

// File: rtl/two_level_solver_if.sv
// ============================================================================
// Module  : two_level_solver_if
// Brief   : Request/result bundle between a requester and the solver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface two_level_solver_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             target;
    logic             busy;
    logic             sol_valid;
    logic             sol_ready;
    logic [3:0]       sol_vec;
    logic             done;
    logic [CNT_W-1:0] sol_count;

    modport master (
        output start, target, sol_ready,
        input  busy, sol_valid, sol_vec, done, sol_count
    );

    modport slave (
        input  start, target, sol_ready,
        output busy, sol_valid, sol_vec, done, sol_count
    );
endinterface

`default_nettype wire

// File: rtl/two_level_solver_eval.sv
// ============================================================================
// Module  : two_level_eval
// Brief   : Combinational evaluator for f = ~((a&b) & ~(c|d)).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module two_level_eval
    import two_level_pkg::*;
(
    input  wire logic [3:0] vec,
    output logic            f
);
    always_comb begin
        f = ~((vec[A_BIT] & vec[B_BIT]) & ~(vec[C_BIT] | vec[D_BIT]));
    end
endmodule

`default_nettype wire

// File: rtl/two_level_solver.sv
// ============================================================================
// Module  : two_level_solver
// Brief   : Scans all input vectors and streams those where f equals target.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module two_level_solver
    import two_level_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int CNT_W = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    two_level_solver_if.slave bus
);
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_t           state;
    logic [N_IN-1:0]  idx;
    logic             tgt;
    logic             f_val;
    logic             busy;
    logic             sol_valid;
    logic [3:0]       sol_vec;
    logic             done;
    logic [CNT_W-1:0] sol_count;

    two_level_eval u_eval (
        .vec (idx),
        .f   (f_val)
    );

    // All outputs come straight from flops; sol_ready only steers next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            tgt       <= 1'b0;
            busy      <= 1'b0;
            sol_valid <= 1'b0;
            sol_vec   <= '0;
            done      <= 1'b0;
            sol_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tgt       <= bus.target;
                        idx       <= '0;
                        sol_count <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (f_val == tgt) begin
                        sol_vec   <= idx;
                        sol_valid <= 1'b1;
                        sol_count <= sol_count + CNT_W'(1);
                        state     <= HOLD;
                    end else if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx <= idx + N_IN'(1);
                    end
                end
                HOLD: begin
                    if (bus.sol_ready) begin
                        sol_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx   <= idx + N_IN'(1);
                            state <= SCAN;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.sol_valid = sol_valid;
    assign bus.sol_vec   = sol_vec;
    assign bus.done      = done;
    assign bus.sol_count = sol_count;
endmodule

`default_nettype wire

// File: tb/tb_two_level_solver.sv
// ============================================================================
// Module  : tb_two_level_solver
// Brief   : Directed bench with a scoreboard model of the solver's output stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_two_level_solver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    two_level_solver_if #(.CNT_W(5)) bus ();

    two_level_solver #(.N_IN(4), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard state
    logic [3:0] exp_vec [16];
    int         exp_n;
    int         beat;
    int         done_cnt;
    bit         armed = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit f_model(input logic [3:0] v);
        bit a, b, c, d;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        return !((a && b) && !(c || d));
    endfunction

    task automatic arm(input bit tgt);
        exp_n = 0;
        for (int v = 0; v < 16; v++) begin
            if (f_model(4'(v)) == tgt) begin
                exp_vec[exp_n] = 4'(v);
                exp_n++;
            end
        end
        beat     = 0;
        done_cnt = 0;
        armed    = 1'b1;
    endtask

    // Compare process: runs on the falling edge while a scan is being tracked.
    always @(negedge clk) begin
        if (armed) begin
            if (bus.sol_valid) begin
                if (beat < exp_n) chk("sol_vec", int'(bus.sol_vec), int'(exp_vec[beat]));
                else              chk("extra_beat", beat, exp_n - 1);
                if (bus.sol_ready) beat++;
            end
            if (bus.done) begin
                chk("sol_count", int'(bus.sol_count), exp_n);
                chk("beats", beat, exp_n);
                done_cnt++;
            end
        end
    end

    task automatic run(input bit tgt, input bit spam, input int stall, output int cyc);
        int stalled;
        stalled = 0;
        arm(tgt);
        bus.sol_ready = (stall == 0);
        bus.target    = tgt;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 300) begin
            @(posedge clk); cyc++; #1;
            bus.start  = spam && (cyc == 3 || cyc == 10 || cyc == 20 || cyc == 29);
            bus.target = spam ? ~tgt : tgt;
            if (stalled < stall && bus.sol_valid) begin
                stalled++;
                chk("stall_valid", int'(bus.sol_valid), 1);
                chk("stall_vec", int'(bus.sol_vec), 0);
                if (stalled == stall) bus.sol_ready = 1'b1;
            end
        end
        bus.start = 1'b0;
        if (cyc >= 300) chk("scan_timeout", cyc, 0);
    endtask

    task automatic settle_and_check(input string name);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_once"}, done_cnt, 1);
        chk({name, "_busy_idle"}, int'(bus.busy), 0);
        armed = 1'b0;
    endtask

    initial begin
        int cyc;
        bit saw_done;
        bus.start     = 1'b0;
        bus.target    = 1'b0;
        bus.sol_ready = 1'b1;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_valid", int'(bus.sol_valid), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_vec",   int'(bus.sol_vec), 0);
        chk("rst_count", int'(bus.sol_count), 0);
        @(posedge clk); #1;

        // 2: target=0 gives the single vector C after 17 cycles
        run(1'b0, 1'b0, 0, cyc);
        chk("t0_latency_lit", cyc, 17);
        chk("t0_latency_model", cyc, 16 + exp_n);
        chk("t0_count_lit", int'(bus.sol_count), 1);
        chk("t0_vec_lit", int'(exp_vec[0]), 12);
        @(posedge clk); #1;
        chk("t0_done_pulse", int'(bus.done), 0);
        settle_and_check("t0");

        // 3: target=1 gives 15 vectors, C skipped
        run(1'b1, 1'b0, 0, cyc);
        chk("t1_latency_lit", cyc, 31);
        chk("t1_count_lit", int'(bus.sol_count), 15);
        chk("t1_model_n", exp_n, 15);
        settle_and_check("t1");

        // 4: backpressure on the first beat
        run(1'b1, 1'b0, 5, cyc);
        chk("stall_count", int'(bus.sol_count), 15);
        settle_and_check("stall");

        // 5: start pulses while busy, including the FIN cycle
        run(1'b1, 1'b1, 0, cyc);
        chk("spam_latency", cyc, 31);
        chk("spam_count", int'(bus.sol_count), 15);
        bus.start  = 1'b1;
        bus.target = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        settle_and_check("spam");
        chk("spam_count_held", int'(bus.sol_count), 15);

        // 6: reset while a beat is pending
        arm(1'b1);
        bus.sol_ready = 1'b0;
        bus.target    = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.sol_valid && cyc < 50) begin
            @(posedge clk); cyc++; #1;
        end
        chk("mid_valid_seen", int'(bus.sol_valid), 1);
        armed = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.sol_ready = 1'b1;
        chk("mid_busy",  int'(bus.busy), 0);
        chk("mid_valid", int'(bus.sol_valid), 0);
        chk("mid_vec",   int'(bus.sol_vec), 0);
        chk("mid_done",  int'(bus.done), 0);
        chk("mid_count", int'(bus.sol_count), 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("mid_no_done", int'(saw_done), 0);

        run(1'b0, 1'b0, 0, cyc);
        chk("post_latency", cyc, 17);
        chk("post_count", int'(bus.sol_count), 1);
        settle_and_check("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
